// File: rtl/apb_pkg.sv
// Shared types and constants for the CPU data-port to APB3 bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h1000_0000;
  localparam int          NUM_SLV_DEFAULT     = 4;
  localparam int          APB_TIMEOUT_DEFAULT = 255;

  localparam int SLV_RAM   = 0;
  localparam int SLV_GPIO  = 1;
  localparam int SLV_UART  = 2;
  localparam int SLV_TIMER = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of NUM_SLV consecutive 4 KiB slave windows.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = NUM_SLV_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic [31:0]        addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel
);

  logic [19:0] page_diff;
  logic        unused_offset;

  // Offset bits belong to the slave, not to the decode.
  assign unused_offset = ^addr[11:0];

  // Unsigned 20-bit difference: pages below the base wrap high and miss.
  always_comb begin
    page_diff = addr[31:12] - BASE_ADDR[31:12];
    hit       = (page_diff < 20'(NUM_SLV));
    sel       = '0;
    for (int n = 0; n < NUM_SLV; n++) begin
      if (page_diff == 20'(n)) sel[n] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Turns one CPU load/store into one APB3 transfer, with miss and timeout
// termination so the memory-access state always sees a ready pulse.
//
// state  | meaning
// IDLE   | waiting for transfer; address/data/direction latched on accept
// SETUP  | PSEL asserted, PENABLE low, exactly one cycle
// ACCESS | PENABLE high, waiting on selected PREADY or timeout
// RESP   | ready (and err) pulse for one cycle, then back to IDLE
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = NUM_SLV_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          TIMEOUT   = APB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                penable_q, penable_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;

  logic                dec_hit;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                slv_ready;
  logic [31:0]         slv_rdata;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR)
  ) u_decoder (
    .addr (addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // PSEL stays one-hot through SETUP/ACCESS, so it doubles as the read mux select.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int n = 0; n < NUM_SLV; n++) begin
      if (psel_q[n]) begin
        slv_ready = slv_ready | PREADY[n];
        slv_rdata = slv_rdata | PRDATA[32*n +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    penable_d  = penable_q;
    psel_d     = psel_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          if (dec_hit) begin
            state_d   = SETUP;
            psel_d    = dec_sel;
            penable_d = 1'b0;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (slv_ready) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? 32'h0 : slv_rdata;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      penable_q  <= 1'b0;
      psel_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      penable_q  <= penable_d;
      psel_q     <= psel_d;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a cycle-count transaction model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            transfer = 1'b0;
  logic            write = 1'b0;
  logic [31:0]     addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            ready;
  logic            err;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE;
  logic            PENABLE;
  logic [NS-1:0]   PSEL;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  apb_master_bridge #(.NUM_SLV(NS), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  // Slave model: the addressed slave answers after cur_waits ACCESS cycles;
  // the others drive random PREADY noise that must be ignored.
  logic [31:0]   slv_data [NS];
  int            cur_idx = 0;
  int            cur_waits = 0;
  logic [NS-1:0] noise = '0;
  int            acc_cycles = 0;

  always @(posedge clk) begin
    if ((|PSEL) && PENABLE) acc_cycles <= acc_cycles + 1;
    else                    acc_cycles <= 0;
  end

  always_comb begin
    PREADY = noise;
    PREADY[cur_idx] = PENABLE && (acc_cycles >= cur_waits);
    for (int n = 0; n < NS; n++) PRDATA[32*n +: 32] = slv_data[n];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [31:0] exp_paddr = '0;
  logic [31:0] exp_pwdata = '0;
  logic        exp_pwrite = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic drive_junk();
    transfer = 1'($urandom);
    write    = 1'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ready"},   32'(ready), 32'd0);
    check_val({tag, "_err"},     32'(err), 32'd0);
    check_val({tag, "_psel"},    32'(PSEL), 32'd0);
    check_val({tag, "_penable"}, 32'(PENABLE), 32'd0);
    check_val({tag, "_paddr"},   PADDR, exp_paddr);
    check_val({tag, "_pwdata"},  PWDATA, exp_pwdata);
    check_val({tag, "_pwrite"},  32'(PWRITE), 32'(exp_pwrite));
    check_val({tag, "_rdata"},   rdata, exp_rdata);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      transfer = 1'b0;
      addr     = $urandom;
      wdata    = $urandom;
      write    = 1'($urandom);
      @(negedge clk);
      check_quiet("idle");
      transfer = 1'b0;
    end
  endtask

  // One CPU request issued in an IDLE cycle, then checked cycle by cycle.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int waits);
    logic [19:0] page;
    logic        hit;
    logic        is_err;
    int          lat;
    logic [NS-1:0] onehot;
    logic [31:0] new_rdata;
    page   = a[31:12] - BASE[31:12];
    hit    = (page < 20'(NS));
    onehot = hit ? NS'(1 << page) : '0;
    if (!hit)            begin lat = 1;        is_err = 1'b1; end
    else if (waits < TO) begin lat = 3 + waits; is_err = 1'b0; end
    else                 begin lat = 2 + TO;   is_err = 1'b1; end
    new_rdata = (hit && !is_err && !wr) ? slv_data[page[1:0]] : 32'h0;

    @(negedge clk);
    cur_idx   = hit ? int'(page) : 0;
    cur_waits = waits;
    noise     = NS'($urandom);
    transfer  = 1'b1;
    write     = wr;
    addr      = a;
    wdata     = wd;
    exp_paddr  = a;
    exp_pwdata = wd;
    exp_pwrite = wr;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) exp_rdata = new_rdata;
      check_val("ready",   32'(ready), 32'(c == lat));
      check_val("err",     32'(err), 32'((c == lat) && is_err));
      check_val("psel",    32'(PSEL), (c < lat) ? 32'(onehot) : 32'd0);
      check_val("penable", 32'(PENABLE), 32'(hit && (c >= 2) && (c < lat)));
      check_val("paddr",   PADDR, exp_paddr);
      check_val("pwdata",  PWDATA, exp_pwdata);
      check_val("pwrite",  32'(PWRITE), 32'(exp_pwrite));
      check_val("rdata",   rdata, exp_rdata);
      drive_junk();
    end
  endtask

  task automatic rand_slaves();
    for (int n = 0; n < NS; n++) slv_data[n] = $urandom;
  endtask

  initial begin
    rand_slaves();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // Zero-wait read from the RAM window.
    slv_data[SLV_RAM] = 32'hDEAD_BEEF;
    do_txn(1'b0, 32'h1000_0008, 32'h0, 0);
    // Write to UART with three wait states.
    do_txn(1'b1, 32'h1000_2010, 32'h1234_5678, 3);
    // Unmapped above and just below the window.
    do_txn(1'b0, 32'h2000_0000, $urandom, 0);
    do_txn(1'b0, 32'h0FFF_FFFC, $urandom, 0);
    do_txn(1'b0, 32'h1000_4000, $urandom, 0);
    // GPIO never answers, then a normal RAM read.
    do_txn(1'b0, 32'h1000_1000, $urandom, 1000);
    rand_slaves();
    do_txn(1'b0, 32'h1000_0004, $urandom, 0);
    // PREADY on the last allowed ACCESS cycle still completes normally.
    do_txn(1'b0, 32'h1000_3020, $urandom, TO - 1);
    do_txn(1'b0, 32'h1000_3024, $urandom, TO);
    // Back-to-back alternating RAM and TIMER.
    for (int i = 0; i < 6; i++) begin
      rand_slaves();
      do_txn(1'($urandom), (i % 2 == 0) ? 32'h1000_0100 : 32'h1000_3100, $urandom, 0);
    end
    do_idle(2);

    // Reset during ACCESS on the timer slave.
    @(negedge clk);
    cur_idx = SLV_TIMER; cur_waits = 1000; noise = '0;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000; wdata = $urandom;
    @(negedge clk);
    transfer = 1'b0;
    @(negedge clk);
    check_val("rst_pre_penable", 32'(PENABLE), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0; exp_rdata = '0;
    check_quiet("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rst_after");
    rand_slaves();
    do_txn(1'b0, 32'h1000_3008, $urandom, 1);

    // Random traffic.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      int          w;
      int          kind;
      rand_slaves();
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        a = BASE + 32'($urandom_range(0, NS - 1) << 12) + 32'($urandom_range(0, 1023) << 2);
      end else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
          1:       a = 32'h0FFF_F000 + 32'($urandom_range(0, 1023) << 2);
          default: a = BASE + 32'(NS << 12) + 32'($urandom_range(0, 4095) << 2);
        endcase
      end
      case ($urandom_range(0, 9))
        6:       w = TO - 1;
        7:       w = TO;
        8:       w = 1000;
        9:       w = 0;
        default: w = $urandom_range(0, 3);
      endcase
      do_txn(1'($urandom), a, $urandom, w);
      if ($urandom_range(0, 3) == 0) do_idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Sits directly downstream of the multi-cycle RV32I datapath's data-memory port.
- Converts each CPU load/store request into one APB3 transfer to one of NUM_SLV memory-mapped slaves (RAM, GPIO, UART, timer).
- Returns read data plus a ready pulse to the control unit, which holds the CPU in its memory-access state until ready.
- Unmapped addresses and slaves that never respond are terminated with an error response, so the CPU never hangs.

Parameters:
- NUM_SLV, 4, number of APB slaves. Slave n decodes addr[31:12] == BASE_ADDR[31:12] + n.
- BASE_ADDR, 32'h1000_0000, base of the slave 0 4 KiB window. Must be 4 KiB aligned.
- TIMEOUT, 255, maximum ACCESS cycles to wait for PREADY before aborting. Range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- transfer  in  1  CPU request. Sampled only in IDLE. CPU holds write/addr/wdata stable until ready.
- write  in  1  1 = store, 0 = load
- addr  in  32  byte address (busAddr)
- wdata  in  32  full word to store (busWData; the datapath has already merged bytes)
- rdata  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  qualifies ready: unmapped address or timeout
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable
- PSEL  out  NUM_SLV  one-hot slave select
- PRDATA  in  NUM_SLV*32  flattened slave read data; slave n occupies [32n+31:32n]
- PREADY  in  NUM_SLV  per-slave ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
  - On a reset edge: state=IDLE, wait counter=0, and rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, PSEL all go to 0.
  - Reset asserted mid-transfer aborts it. No ready is issued for the aborted request.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, transfer=1:
  - Latch addr, wdata and write into PADDR, PWDATA and PWRITE. Decode the slave index.
  - Hit: next state SETUP, PSEL[idx]=1, PENABLE=0.
  - Miss: next state RESP with ready=1, err=1, rdata=0. No PSEL is ever asserted.
- IDLE, transfer=0: no change. PADDR, PWDATA and PWRITE hold their last values.
- SETUP: exactly one cycle. Next state ACCESS with PENABLE=1, PSEL unchanged, wait counter cleared.
- ACCESS, PREADY[idx]=1:
  - Next state RESP. PSEL and PENABLE go to 0.
  - ready=1, err=0.
  - rdata = PRDATA[idx] for a read, 0 for a write.
- ACCESS, PREADY[idx]=0: counter increments.
  - When the counter reaches TIMEOUT-1 with PREADY still low: next state RESP, PSEL and PENABLE go to 0, ready=1, err=1, rdata=0.
  - PREADY arriving in the same cycle as the timeout threshold wins: normal completion.
- Only the selected slave's PREADY and PRDATA are observed. Other slaves' PREADY are ignored.
- RESP: ready and err are high for this single cycle only. Next state IDLE, ready and err cleared. rdata holds its value until the next completion.
- transfer outside IDLE is ignored. A request held high through RESP is not re-accepted. A new request needs one IDLE cycle, so back-to-back transfers start 4 cycles apart minimum.
- Latency, transfer sampled in cycle 0:
  - Zero-wait hit: SETUP cycle 1, ACCESS cycle 2, ready cycle 3.
  - Each slave wait state adds 1 cycle.
  - Miss: ready in cycle 1.
- PADDR is the full byte address. Slaves apply their own offset using PADDR[11:0].
- Index arithmetic: the difference addr[31:12] - BASE_ADDR[31:12] is computed unsigned on 20 bits. It is a hit iff the difference is < NUM_SLV. An address below the base wraps to a large value and is a miss.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - BASE_ADDR default and slave index constants (SLV_RAM=0, SLV_GPIO=1, SLV_UART=2, SLV_TIMER=3)
  - APB_TIMEOUT_DEFAULT
- One sub-module: apb_addr_decoder. Combinational: addr in; hit and one-hot select out. Parameterised by NUM_SLV and BASE_ADDR.
- The FSM, latches, counter and read mux stay in apb_master_bridge.

Test Plan:
- Read, slave 0 at 0x1000_0008, PREADY[0] tied 1, PRDATA[31:0]=0xDEAD_BEEF.
  - PSEL=0001 in cycle 1, PENABLE=1 in cycle 2.
  - ready=1, err=0, rdata=0xDEAD_BEEF in cycle 3 only.
- Write, slave 2 at 0x1000_2010, wdata=0x1234_5678, PREADY[2] low for 3 ACCESS cycles.
  - PWRITE=1, PADDR=0x1000_2010, PWDATA=0x1234_5678 stable SETUP through ACCESS.
  - ready in cycle 6, rdata=0.
- Unmapped 0x2000_0000, then 0x0FFF_FFFC.
  - PSEL never asserted.
  - ready=1, err=1, rdata=0 one cycle after transfer, each time.
- Timeout, slave 1 PREADY stuck 0, TIMEOUT=8.
  - ACCESS lasts 8 cycles, PSEL/PENABLE drop.
  - ready=1, err=1, rdata=0.
  - A following read to slave 0 completes normally.
- transfer held high continuously with alternating addresses on slaves 0 and 3 (zero-wait).
  - Exactly one transfer per 4 cycles.
  - No toggling of transfer inputs during a transfer alters PADDR.
- reset pulsed during ACCESS on slave 3 with PREADY=0.
  - Next cycle: all outputs 0, state IDLE, no ready.
  - A new read after reset completes with correct data.
